// File: rtl/step_pulse_bank.sv
// step_pulse_bank: per-channel button synchroniser, debouncer and press/release pulse generator.
// Define REPEAT_EN to add hold-to-repeat press pulses (IDLE/DELAY/RATE FSM per channel).
module step_pulse_bank #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_n,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            any_press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_CH-1:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [N_CH-1:0]                  pressed_q, pressed_d;
  logic [N_CH-1:0]                  pressed_dly_q, pressed_dly_d;
  logic [N_CH-1:0]                  press_pulse_q, press_pulse_d;
  logic [N_CH-1:0]                  release_pulse_q, release_pulse_d;
  logic                             any_press_q, any_press_d;
  logic [N_CH-1:0]                  rise, fall, rpt_fire;

  // A mismatch is sync_out equal to pressed, since the raw input is active-low.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], btn_n[i]};
      db_cnt_d[i]  = '0;
      pressed_d[i] = pressed_q[i];
      if (sync_q[i][SYNC_STAGES-1] == pressed_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          pressed_d[i] = ~pressed_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = pressed_q & ~pressed_dly_q;
  assign fall = ~pressed_q & pressed_dly_q;

  always_comb begin
    pressed_dly_d   = pressed_q;
    press_pulse_d   = rise | rpt_fire;
    release_pulse_d = fall;
    any_press_d     = |press_pulse_d;
  end

`ifdef REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_RATE
  } rpt_state_e;

  rpt_state_e                rpt_state_q [N_CH];
  rpt_state_e                rpt_state_d [N_CH];
  logic [N_CH-1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  // Repeats stop on the edge where pressed is seen low, so none lands on or after release_pulse.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      rpt_fire[i]    = 1'b0;
      case (rpt_state_q[i])
        RPT_IDLE: begin
          if (rise[i]) begin
            rpt_state_d[i] = RPT_DELAY;
            rpt_cnt_d[i]   = '0;
          end
        end
        RPT_DELAY: begin
          if (!pressed_q[i]) begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_cnt_d[i]   = '0;
          end else if (rpt_cnt_q[i] == DELAY_LAST) begin
            rpt_fire[i]    = 1'b1;
            rpt_state_d[i] = RPT_RATE;
            rpt_cnt_d[i]   = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
          end
        end
        RPT_RATE: begin
          if (!pressed_q[i]) begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_cnt_d[i]   = '0;
          end else if (rpt_cnt_q[i] == PERIOD_LAST) begin
            rpt_fire[i]  = 1'b1;
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
          end
        end
        default: begin
          rpt_state_d[i] = RPT_IDLE;
          rpt_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        rpt_state_q[i] <= RPT_IDLE;
      end
      rpt_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        rpt_state_q[i] <= rpt_state_d[i];
      end
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire = '0;

  // Repeat timing parameters have no effect when REPEAT_EN is undefined.
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_repeat_cfg_unused
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q          <= '1;
      db_cnt_q        <= '0;
      pressed_q       <= '0;
      pressed_dly_q   <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      any_press_q     <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      db_cnt_q        <= db_cnt_d;
      pressed_q       <= pressed_d;
      pressed_dly_q   <= pressed_dly_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      any_press_q     <= any_press_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign any_press     = any_press_q;

endmodule

// File: doc/step_pulse_bank.md
# step_pulse_bank

Multi-channel debounced push-button front end that replaces single-button step pulse generation on the 6502 board. Each of N_CH active-low raw buttons is synchronised, debounced with a programmable stable-time counter, and converted into one-cycle press and release pulses plus a clean level. An optional hold-to-repeat mode re-fires press pulses while a button is held, for single-step and monitor-key use.

## Interface
- N_CH, 4: number of independent button channels (≥1)
- SYNC_STAGES, 3: synchroniser flip-flops per channel (≥2)
- DEBOUNCE_CYCLES, 1_000_000: consecutive mismatching cycles required to accept a new level (≥1; 20 ms at 50 MHz)
- REPEAT_DELAY, 25_000_000: cycles from the initial press pulse to the first repeat (≥2; used only with REPEAT_EN)
- REPEAT_PERIOD, 5_000_000: cycles between subsequent repeats (≥2; used only with REPEAT_EN)

- clk_in  input  1  system clock, 50 MHz
- rst  input  1  synchronous reset, active-high
- btn_n  input  N_CH  raw asynchronous buttons, low = pressed
- pressed  output  N_CH  debounced level, high = pressed
- press_pulse  output  N_CH  one-cycle pulse on accepted press (and on repeats when REPEAT_EN)
- release_pulse  output  N_CH  one-cycle pulse on accepted release
- any_press  output  1  registered OR of press_pulse, same cycle as press_pulse

## Operation
- Channels are fully independent; no shared counters, no priority.
- Synchroniser: shift chain per channel; sync_out = last stage. Reset presets all stages to 1 (released).
- Debounce: per-channel counter, width $clog2(DEBOUNCE_CYCLES+1). Each cycle where the inverted sync_out ≠ pressed, the counter increments; when it equals DEBOUNCE_CYCLES-1 on such a cycle, pressed toggles at that edge and the counter clears. Any cycle where they match clears the counter. A glitch shorter than DEBOUNCE_CYCLES cycles never changes pressed.
- Edge detect: press_pulse[i] = pressed[i] rose on the previous edge; release_pulse[i] = pressed[i] fell on the previous edge. All outputs registered.
- Repeat FSM per channel (REPEAT_EN only): states IDLE, DELAY, RATE.
  - IDLE → DELAY on initial press_pulse; counter cleared.
  - DELAY: counts while pressed; at REPEAT_DELAY cycles after the initial pulse emit press_pulse, → RATE, counter cleared.
  - RATE: emit press_pulse every REPEAT_PERIOD cycles.
  - Any state → IDLE when pressed falls; no repeat pulse in the same cycle as or after release_pulse.
- press_pulse and release_pulse on one channel are never asserted together.

## Timing
- Reset: pressed=0, press_pulse=0, release_pulse=0, any_press=0, all counters 0, FSMs IDLE, sync stages=1.
- Latency: input stable at the new level from edge k → pressed changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 → pulse high for the cycle following edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
- Pulse width exactly 1 clk_in cycle; minimum spacing between press and release pulses on one channel is DEBOUNCE_CYCLES cycles.
- Button held through reset: after rst falls, behaves as a fresh press, one press_pulse after SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
- rst asserted mid-debounce or mid-repeat: everything returns to reset values at that edge; no pulse emitted for the aborted event.
- Repeat pulses: initial at t, repeats at t+REPEAT_DELAY, t+REPEAT_DELAY+REPEAT_PERIOD, …

## Configuration
- REPEAT_EN defined: repeat FSM and its counters are instantiated; press_pulse includes repeat pulses.
- REPEAT_EN undefined: no repeat logic synthesised; press_pulse fires once per accepted press; REPEAT_DELAY/REPEAT_PERIOD ignored.

## Test plan
- N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4: drive btn_n[0] 1→0 before edge 10, hold → pressed[0] high after edge 15, press_pulse[0] and any_press high for the one cycle after edge 16; channel 1 silent.
- Same config, btn_n[1] low for 3 cycles then high → no change on pressed[1], no pulses.
- Press then release ch0 after 20 cycles → exactly one press_pulse and one release_pulse, release 20 cycles after press.
- Both channels pressed on the same edge → both press_pulse bits high in the same cycle, any_press single-cycle high.
- REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4, hold ch0 for 30 cycles after initial pulse at t → pulses at t, t+10, t+14, t+18, …, t+30; none after release.
- rst asserted 2 cycles into debounce of a press → all outputs 0; with button still held, one press_pulse 7 cycles after rst deasserts.
